// File: rtl/vga_pkg.sv
// Shared VGA raster definitions: 640x480@60 timing values and the coordinate type
// used by the timing generator and every renderer downstream of it.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  localparam int H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // True when c lies in the half-open window [lo, lo+len).
  function automatic logic in_window(coord_t c, int lo, int len);
    return (int'(c) >= lo) && (int'(c) < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster timing generator: cascaded h/v modulo counters advanced by pix_en, with
// every decoded output registered from the next-count value so they share one edge.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_VISIBLE   = VGA_H_VISIBLE,
  parameter int   H_FP        = VGA_H_FP,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BP        = VGA_H_BP,
  parameter int   V_VISIBLE   = VGA_V_VISIBLE,
  parameter int   V_FP        = VGA_V_FP,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BP        = VGA_V_BP,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output coord_t     h_cnt,
  output coord_t     v_cnt,
  output coord_t     x,
  output coord_t     y,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int     HTOT  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int     VTOT  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam coord_t H_MAX = coord_t'(HTOT - 1);
  localparam coord_t V_MAX = coord_t'(VTOT - 1);

  coord_t h_nxt;
  coord_t v_nxt;
  logic   de_nxt;
  logic   hsync_nxt;
  logic   vsync_nxt;
  logic   h_wrap;
  logic   f_wrap;

  // Next raster position and its decode; only committed on a pixel strobe.
  always_comb begin
    h_wrap = (h_cnt == H_MAX);
    f_wrap = h_wrap && (v_cnt == V_MAX);
    h_nxt  = h_wrap ? '0 : coord_t'(h_cnt + 10'd1);
    if (f_wrap)
      v_nxt = '0;
    else if (h_wrap)
      v_nxt = coord_t'(v_cnt + 10'd1);
    else
      v_nxt = v_cnt;
    de_nxt    = (int'(h_nxt) < H_VISIBLE) && (int'(v_nxt) < V_VISIBLE);
    hsync_nxt = in_window(h_nxt, H_VISIBLE + H_FP, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_nxt = in_window(v_nxt, V_VISIBLE + V_FP, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  // Reset parks the raster on the last pixel so the first strobe opens frame 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt       <= H_MAX;
      v_cnt       <= V_MAX;
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= 8'hFF;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        h_cnt       <= h_nxt;
        v_cnt       <= v_nxt;
        x           <= de_nxt ? h_nxt : '0;
        y           <= de_nxt ? v_nxt : '0;
        de          <= de_nxt;
        hsync       <= hsync_nxt;
        vsync       <= vsync_nxt;
        line_start  <= h_wrap;
        frame_start <= f_wrap;
        if (f_wrap)
          frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640×480@60 VGA output path. It steps a horizontal/vertical pixel counter on each pixel-enable strobe and produces the registered pixel coordinates `x`/`y` consumed by every layer renderer (sky, road, sprites, HUD). It also produces `de`, `hsync`, `vsync`, line/frame start pulses and a frame counter. It sits directly upstream of the renderers; the compositor and the VGA pins consume its sync outputs.

## Interface
Parameters:
- `H_VISIBLE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, active lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_ACTIVE`, 1'b0, level of hsync/vsync while asserted (0 = active-low)

Ports:
- `clk` in 1: system clock, 100 MHz
- `reset` in 1: asynchronous, active-high reset
- `pix_en` in 1: one-`clk` pixel strobe (25 MHz rate, from the clock divider)
- `h_cnt` out 10: raw horizontal counter, 0..H_TOTAL-1
- `v_cnt` out 10: raw vertical counter, 0..V_TOTAL-1
- `x` out 10: pixel column, 0..639; 0 outside the active area
- `y` out 10: pixel row, 0..479; 0 outside the active area
- `de` out 1: active-video flag
- `hsync` out 1: horizontal sync
- `vsync` out 1: vertical sync
- `line_start` out 1: one-`clk` pulse when `h_cnt` becomes 0
- `frame_start` out 1: one-`clk` pulse when (`h_cnt`,`v_cnt`) becomes (0,0)
- `frame_cnt` out 8: frame counter, wraps 255→0

## Operation
- Derived totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- On `pix_en`:
  - `h_cnt` increments.
  - At H_TOTAL-1, `h_cnt` wraps to 0 and `v_cnt` increments.
  - When both counters are at their maximum, both wrap to 0.
- Without `pix_en`: every output holds its value, except `line_start` and `frame_start`, which return to 0.
- `de` = 1 iff `h_cnt` < H_VISIBLE and `v_cnt` < V_VISIBLE.
- `x` = `h_cnt` when `de` = 1, else 0. `y` = `v_cnt` when `de` = 1, else 0. Renderers therefore see (0,0) during blanking.
- `hsync` = SYNC_ACTIVE for `h_cnt` in [656, 751]; otherwise ~SYNC_ACTIVE.
- `vsync` = SYNC_ACTIVE for `v_cnt` in [490, 491]; otherwise ~SYNC_ACTIVE. Both windows are computed from the parameters.
- `frame_cnt` increments on every `frame_start`.
- No state machine: two cascaded modulo counters plus registered decode.

## Timing
- Reset values:
  - `h_cnt` = H_TOTAL-1, `v_cnt` = V_TOTAL-1 (last pixel of a frame)
  - `x` = `y` = 0, `de` = 0
  - `hsync` = `vsync` = ~SYNC_ACTIVE
  - `line_start` = `frame_start` = 0
  - `frame_cnt` = 8'hFF
- All outputs are registered and decoded from the next-count value. On the `clk` edge that consumes `pix_en`, the counters and every decoded output change together, so there is zero skew between `x`/`y` and `de`/`hsync`/`vsync`.
- The first `pix_en` after reset yields:
  - `h_cnt` = `v_cnt` = 0, `x` = `y` = 0, `de` = 1
  - `line_start` = `frame_start` = 1
  - `frame_cnt` = 0
- Pulses are high for exactly one `clk` cycle, namely the cycle following the qualifying edge, independent of the `pix_en` spacing.
- `pix_en` on consecutive `clk` cycles is legal; the counters then advance every cycle.
- Reset asserted mid-frame: all outputs return to their reset values asynchronously. The frame restarts at (0,0) on the first `pix_en` after release.
- Downstream renderers are combinational. The compositor registers one stage and delays `hsync`/`vsync`/`de` by one `pix_en` to match.

## Structure
- Add `vga_pkg` with:
  - `localparam`s for the 640×480@60 porch and sync values, used as parameter defaults
  - H_TOTAL / V_TOTAL
  - `typedef logic [9:0] coord_t` for `x`, `y`, `h_cnt`, `v_cnt`
- `color_pkg` is untouched.
- Single flat module; no sub-module needed.

## Test plan
- Reset, release, one `pix_en` → `h_cnt`=0, `v_cnt`=0, `de`=1, `line_start`=1, `frame_start`=1, `frame_cnt`=0; both pulses low one cycle later.
- Drive `pix_en` every 4th `clk` for one full line → `de` falls at `h_cnt`=640; `hsync` is low for exactly 96 strobes starting at `h_cnt`=656; `line_start` fires again after 800 strobes.
- Drive one full frame → `vsync` is low only on lines 490–491; `y` never exceeds 479; `x`=`y`=0 whenever `de`=0; the next `frame_start` comes after 420 000 strobes.
- Hold `pix_en`=0 for 50 cycles mid-line → all outputs frozen; pulses stay 0.
- Assert `reset` at `h_cnt`=300, `v_cnt`=200 → outputs return to their reset values within the same cycle; the first post-release strobe gives (0,0) with `frame_start`=1 and `frame_cnt`=0.
- Run 256 frames (or force the count) → `frame_cnt` wraps 255→0 on `frame_start`.
